// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared encodings for the bus-register transfer controllers.
// State codes and register RW polarities used by every controller on the DATA bus.
package bus_xfer_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   localparam logic RW_DRIVE = 1'b1;
   localparam logic RW_LOAD  = 1'b0;

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Requester and register-bank signals of the DATA bus transfer controller.
// master = requester/bank side, slave = controller side.
interface bus_xfer_ctrl_if #(
   parameter int NUM_REGS = 8,
   parameter int IDX_W    = 3,
   parameter int NUM_REQ  = 4
);
   logic [NUM_REQ-1:0]       REQ_VALID;
   logic [NUM_REQ*IDX_W-1:0] REQ_SRC;
   logic [NUM_REQ*IDX_W-1:0] REQ_DST;
   logic [NUM_REQ-1:0]       REQ_ACK;
   logic                     XFER_ERR;
   logic [NUM_REGS-1:0]      REG_ENABLE;
   logic [NUM_REGS-1:0]      REG_RW;
   logic                     BUSY;

   modport master (
      output REQ_VALID, REQ_SRC, REQ_DST,
      input  REQ_ACK, XFER_ERR, REG_ENABLE, REG_RW, BUSY
   );

   modport slave (
      input  REQ_VALID, REQ_SRC, REQ_DST,
      output REQ_ACK, XFER_ERR, REG_ENABLE, REG_RW, BUSY
   );
endinterface

// File: rtl/bus_xfer_ctrl_rr_arbiter.sv
// Round-robin pick of the first request at or after ptr+1; purely combinational.
// Zero latency; requests not granted simply wait for a later pick.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   idx_o,
   output logic               any_o
);
   int cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      // k = NUM_REQ wraps back to ptr itself, so it is searched last
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(ptr_i) + k) % NUM_REQ;
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = PTR_W'(cand);
         end
      end
   end
endmodule

// File: rtl/bus_xfer_ctrl.sv
// Arbitrates register-to-register DATA bus transfers: XFER 1 cycle after sampling, ACK 1 cycle later.
// Requesters hold REQ_VALID until ACK; at most one transfer per 3 cycles, one bus driver per cycle.
module bus_xfer_ctrl
   import bus_xfer_ctrl_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int IDX_W    = 3,
   parameter int NUM_REQ  = 4
) (
   input  logic           CLOCK,
   input  logic           RESET,
   bus_xfer_ctrl_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e              state_q;
   logic [PTR_W-1:0]    ptr_q;
   logic [PTR_W-1:0]    id_q;
   logic [NUM_REGS-1:0] en_q;
   logic [NUM_REGS-1:0] rw_q;
   logic [NUM_REQ-1:0]  ack_q;
   logic                err_q;

   logic [NUM_REQ-1:0]  win_gnt;
   logic [PTR_W-1:0]    win_idx;
   logic                win_any;
   logic [IDX_W-1:0]    win_src;
   logic [IDX_W-1:0]    win_dst;
   logic                win_legal;
   logic [NUM_REGS-1:0] en_d;
   logic [NUM_REGS-1:0] rw_d;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .req_i (bus.REQ_VALID),
      .ptr_i (ptr_q),
      .gnt_o (win_gnt),
      .idx_o (win_idx),
      .any_o (win_any)
   );

   assign win_src   = bus.REQ_SRC[int'(win_idx)*IDX_W +: IDX_W];
   assign win_dst   = bus.REQ_DST[int'(win_idx)*IDX_W +: IDX_W];
   assign win_legal = (win_src != win_dst) && (int'(win_src) < NUM_REGS)
                      && (int'(win_dst) < NUM_REGS);

   // Only consumed for legal requests, so out-of-range indices never reach a bit
   always_comb begin
      en_d = '0;
      rw_d = {NUM_REGS{RW_DRIVE}};
      for (int j = 0; j < NUM_REGS; j++) begin
         if (int'(win_src) == j) en_d[j] = 1'b1;
         if (int'(win_dst) == j) begin
            en_d[j] = 1'b1;
            rw_d[j] = RW_LOAD;
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         id_q    <= '0;
         en_q    <= '0;
         rw_q    <= {NUM_REGS{RW_DRIVE}};
         ack_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_any) begin
                  id_q  <= win_idx;
                  ptr_q <= win_idx;
                  if (win_legal) begin
                     state_q <= ST_XFER;
                     en_q    <= en_d;
                     rw_q    <= rw_d;
                  end else begin
                     state_q <= ST_ACK;
                     ack_q   <= win_gnt;
                     err_q   <= 1'b1;
                  end
               end
            end
            ST_XFER: begin
               state_q <= ST_ACK;
               en_q    <= '0;
               rw_q    <= {NUM_REGS{RW_DRIVE}};
               ack_q   <= NUM_REQ'(1) << id_q;
               err_q   <= 1'b0;
            end
            ST_ACK: begin
               state_q <= ST_IDLE;
               ack_q   <= '0;
               err_q   <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               en_q    <= '0;
               rw_q    <= {NUM_REGS{RW_DRIVE}};
               ack_q   <= '0;
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.REG_ENABLE = en_q;
   assign bus.REG_RW     = rw_q;
   assign bus.REQ_ACK    = ack_q;
   assign bus.XFER_ERR   = err_q;
   assign bus.BUSY       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: directed scenarios plus randomized requests against a round-robin model.
// A small register bank model follows REG_ENABLE/REG_RW and checks for a single bus driver.
module tb_bus_xfer_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   logic [15:0] bank [8];
   bit          m_vld [4];
   int          m_src [4];
   int          m_dst [4];

   always #5 clk = ~clk;

   bus_xfer_ctrl_if #(.NUM_REGS(8), .IDX_W(3), .NUM_REQ(4)) bif ();
   bus_xfer_ctrl #(.NUM_REGS(8), .IDX_W(3), .NUM_REQ(4)) dut (
      .CLOCK (clk),
      .RESET (rst_n),
      .bus   (bif)
   );

   bus_xfer_ctrl_if #(.NUM_REGS(6), .IDX_W(3), .NUM_REQ(4)) bif6 ();
   bus_xfer_ctrl #(.NUM_REGS(6), .IDX_W(3), .NUM_REQ(4)) dut6 (
      .CLOCK (clk),
      .RESET (rst_n),
      .bus   (bif6)
   );

   // Register bank: exactly one driver whenever any register is enabled
   always @(posedge clk) begin
      int          drivers;
      logic [15:0] data;
      drivers = 0;
      data    = '0;
      if (bif.REG_ENABLE != 8'h00) begin
         for (int j = 0; j < 8; j++)
            if (bif.REG_ENABLE[j] && bif.REG_RW[j]) begin
               drivers++;
               data = bank[j];
            end
         total++;
         if (drivers != 1) begin
            bad++;
            $display("FAIL bus_drivers: got %0d drivers, want 1", drivers);
         end
         for (int j = 0; j < 8; j++)
            if (bif.REG_ENABLE[j] && !bif.REG_RW[j]) bank[j] = data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit v, input int s, input int d);
      bif.REQ_VALID[i]       = v;
      bif.REQ_SRC[i*3 +: 3]  = 3'(s);
      bif.REQ_DST[i*3 +: 3]  = 3'(d);
   endtask

   task automatic rand_req(input int i);
      m_vld[i] = ($urandom_range(0, 3) != 0);
      m_src[i] = $urandom_range(0, 7);
      m_dst[i] = ($urandom_range(0, 4) == 0) ? m_src[i] : (m_src[i] + $urandom_range(1, 7)) % 8;
      set_req(i, m_vld[i], m_src[i], m_dst[i]);
   endtask

   task automatic do_reset();
      bif.REQ_VALID  = '0;
      bif6.REQ_VALID = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bif.REQ_VALID  = '0;
      bif.REQ_SRC    = '0;
      bif.REQ_DST    = '0;
      bif6.REQ_VALID = '0;
      bif6.REQ_SRC   = '0;
      bif6.REQ_DST   = '0;
      rst_n = 1'b0;
      step();
      step();
      total++;
      if (bif.REG_ENABLE !== 8'h00 || bif.REG_RW !== 8'hFF) begin
         bad++;
         $display("FAIL reset_bus: en=%h rw=%h, want 00/ff", bif.REG_ENABLE, bif.REG_RW);
      end
      total++;
      if (bif.REQ_ACK !== 4'h0 || bif.XFER_ERR !== 1'b0 || bif.BUSY !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl: ack=%b err=%b busy=%b, want 0000/0/0",
                  bif.REQ_ACK, bif.XFER_ERR, bif.BUSY);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      bank[2] = 16'hA5C3;
      bank[5] = 16'h0000;
      set_req(0, 1, 2, 5);
      step();
      total++;
      if (bif.REG_ENABLE !== 8'b0010_0100 || bif.REG_RW !== 8'b1101_1111 || bif.BUSY !== 1'b1) begin
         bad++;
         $display("FAIL single_xfer: en=%b rw=%b busy=%b, want 00100100/11011111/1",
                  bif.REG_ENABLE, bif.REG_RW, bif.BUSY);
      end
      step();
      total++;
      if (bif.REQ_ACK !== 4'b0001 || bif.XFER_ERR !== 1'b0 || bif.REG_ENABLE !== 8'h00) begin
         bad++;
         $display("FAIL single_ack: ack=%b err=%b en=%b, want 0001/0/0",
                  bif.REQ_ACK, bif.XFER_ERR, bif.REG_ENABLE);
      end
      bif.REQ_VALID[0] = 1'b0;
      step();
      total++;
      if (bif.REQ_ACK !== 4'b0000 || bif.BUSY !== 1'b0) begin
         bad++;
         $display("FAIL single_idle: ack=%b busy=%b, want 0000/0", bif.REQ_ACK, bif.BUSY);
      end
      total++;
      if (bank[5] !== 16'hA5C3) begin
         bad++;
         $display("FAIL single_data: reg5=%h, want a5c3", bank[5]);
      end
   endtask

   task automatic test_contention();
      do_reset();
      set_req(1, 1, 3, 4);
      set_req(3, 1, 6, 0);
      step();
      total++;
      if (bif.REG_ENABLE !== 8'h18 || bif.REG_RW !== 8'hEF) begin
         bad++;
         $display("FAIL cont_xfer1: en=%h rw=%h, want 18/ef", bif.REG_ENABLE, bif.REG_RW);
      end
      step();
      total++;
      if (bif.REQ_ACK !== 4'b0010) begin
         bad++;
         $display("FAIL cont_ack1: ack=%b, want 0010", bif.REQ_ACK);
      end
      step();
      bif.REQ_VALID[1] = 1'b0;
      total++;
      if (bif.REQ_ACK !== 4'b0000 || bif.BUSY !== 1'b0) begin
         bad++;
         $display("FAIL cont_gap: ack=%b busy=%b, want 0000/0", bif.REQ_ACK, bif.BUSY);
      end
      step();
      total++;
      if (bif.REG_ENABLE !== 8'h41 || bif.REG_RW !== 8'hFE) begin
         bad++;
         $display("FAIL cont_xfer3: en=%h rw=%h, want 41/fe", bif.REG_ENABLE, bif.REG_RW);
      end
      step();
      total++;
      if (bif.REQ_ACK !== 4'b1000 || bif.XFER_ERR !== 1'b0) begin
         bad++;
         $display("FAIL cont_ack3: ack=%b err=%b, want 1000/0", bif.REQ_ACK, bif.XFER_ERR);
      end
      bif.REQ_VALID[3] = 1'b0;
      step();
   endtask

   task automatic test_fairness();
      int         fs [4];
      int         fd [4];
      int         w;
      logic [7:0] exp_en;
      logic [3:0] exp_ack;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         fs[i] = $urandom_range(0, 7);
         fd[i] = (fs[i] + $urandom_range(1, 7)) % 8;
         set_req(i, 1, fs[i], fd[i]);
      end
      for (int n = 0; n < 12; n++) begin
         w = n % 4;
         exp_en = '0;
         exp_en[fs[w]] = 1'b1;
         exp_en[fd[w]] = 1'b1;
         exp_ack = '0;
         exp_ack[w] = 1'b1;
         step();
         total++;
         if (bif.REG_ENABLE !== exp_en) begin
            bad++;
            $display("FAIL fair_xfer[%0d]: en=%b, want %b", n, bif.REG_ENABLE, exp_en);
         end
         step();
         total++;
         if (bif.REQ_ACK !== exp_ack) begin
            bad++;
            $display("FAIL fair_ack[%0d]: ack=%b, want %b", n, bif.REQ_ACK, exp_ack);
         end
         step();
         fs[w] = $urandom_range(0, 7);
         fd[w] = (fs[w] + $urandom_range(1, 7)) % 8;
         set_req(w, 1, fs[w], fd[w]);
      end
      bif.REQ_VALID = '0;
      step();
      step();
   endtask

   task automatic test_illegal();
      do_reset();
      set_req(2, 1, 4, 4);
      step();
      total++;
      if (bif.REG_ENABLE !== 8'h00 || bif.REQ_ACK !== 4'b0100 || bif.XFER_ERR !== 1'b1
          || bif.BUSY !== 1'b1) begin
         bad++;
         $display("FAIL illegal_ack: en=%h ack=%b err=%b busy=%b, want 00/0100/1/1",
                  bif.REG_ENABLE, bif.REQ_ACK, bif.XFER_ERR, bif.BUSY);
      end
      bif.REQ_VALID[2] = 1'b0;
      step();
      total++;
      if (bif.REQ_ACK !== 4'b0000 || bif.XFER_ERR !== 1'b0 || bif.BUSY !== 1'b0) begin
         bad++;
         $display("FAIL illegal_idle: ack=%b err=%b busy=%b, want 0000/0/0",
                  bif.REQ_ACK, bif.XFER_ERR, bif.BUSY);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(0, 1, 1, 2);
      step();
      total++;
      if (bif.REG_ENABLE !== 8'h06) begin
         bad++;
         $display("FAIL midrst_xfer: en=%h, want 06", bif.REG_ENABLE);
      end
      rst_n = 1'b0;
      bif.REQ_VALID = '0;
      step();
      total++;
      if (bif.REG_ENABLE !== 8'h00 || bif.BUSY !== 1'b0 || bif.REQ_ACK !== 4'b0000) begin
         bad++;
         $display("FAIL midrst_abort: en=%h busy=%b ack=%b, want 00/0/0000",
                  bif.REG_ENABLE, bif.BUSY, bif.REQ_ACK);
      end
      rst_n = 1'b1;
      step();
      total++;
      if (bif.REQ_ACK !== 4'b0000 || bif.BUSY !== 1'b0) begin
         bad++;
         $display("FAIL midrst_noack: ack=%b busy=%b, want 0000/0", bif.REQ_ACK, bif.BUSY);
      end
      set_req(2, 1, 3, 5);
      set_req(0, 1, 6, 7);
      step();
      total++;
      if (bif.REG_ENABLE !== 8'hC0 || bif.REG_RW !== 8'h7F) begin
         bad++;
         $display("FAIL midrst_first: en=%h rw=%h, want c0/7f", bif.REG_ENABLE, bif.REG_RW);
      end
      step();
      total++;
      if (bif.REQ_ACK !== 4'b0001) begin
         bad++;
         $display("FAIL midrst_ack: ack=%b, want 0001", bif.REQ_ACK);
      end
      bif.REQ_VALID = '0;
      step();
      step();
   endtask

   task automatic test_out_of_range();
      do_reset();
      bif6.REQ_VALID = 4'b0001;
      bif6.REQ_SRC   = 12'h007;
      bif6.REQ_DST   = 12'h001;
      step();
      total++;
      if (bif6.REG_ENABLE !== 6'h00 || bif6.REQ_ACK !== 4'b0001 || bif6.XFER_ERR !== 1'b1) begin
         bad++;
         $display("FAIL oor_src: en=%b ack=%b err=%b, want 000000/0001/1",
                  bif6.REG_ENABLE, bif6.REQ_ACK, bif6.XFER_ERR);
      end
      bif6.REQ_SRC = 12'h000;
      bif6.REQ_DST = 12'h006;
      step();
      step();
      total++;
      if (bif6.REG_ENABLE !== 6'h00 || bif6.REQ_ACK !== 4'b0001 || bif6.XFER_ERR !== 1'b1) begin
         bad++;
         $display("FAIL oor_dst: en=%b ack=%b err=%b, want 000000/0001/1",
                  bif6.REG_ENABLE, bif6.REQ_ACK, bif6.XFER_ERR);
      end
      bif6.REQ_SRC = 12'h005;
      bif6.REQ_DST = 12'h001;
      step();
      step();
      total++;
      if (bif6.REG_ENABLE !== 6'b100010 || bif6.REG_RW !== 6'b111101) begin
         bad++;
         $display("FAIL oor_legal: en=%b rw=%b, want 100010/111101", bif6.REG_ENABLE, bif6.REG_RW);
      end
      step();
      total++;
      if (bif6.REQ_ACK !== 4'b0001 || bif6.XFER_ERR !== 1'b0) begin
         bad++;
         $display("FAIL oor_legal_ack: ack=%b err=%b, want 0001/0", bif6.REQ_ACK, bif6.XFER_ERR);
      end
      bif6.REQ_VALID = '0;
      step();
   endtask

   task automatic test_random();
      int         m_ptr;
      int         w;
      int         c;
      int         s;
      int         d;
      logic [7:0] exp_en;
      logic [7:0] exp_rw;
      logic [3:0] exp_ack;
      do_reset();
      m_ptr = 3;
      for (int i = 0; i < 4; i++) rand_req(i);
      for (int r = 0; r < 60; r++) begin
         w = -1;
         for (int k = 1; k <= 4; k++) begin
            c = (m_ptr + k) % 4;
            if (w < 0 && m_vld[c]) w = c;
         end
         step();
         if (w < 0) begin
            total++;
            if (bif.BUSY !== 1'b0 || bif.REQ_ACK !== 4'b0000) begin
               bad++;
               $display("FAIL rand_idle[%0d]: busy=%b ack=%b, want 0/0000", r, bif.BUSY, bif.REQ_ACK);
            end
            for (int i = 0; i < 4; i++) rand_req(i);
         end else begin
            s = m_src[w];
            d = m_dst[w];
            m_ptr = w;
            exp_ack = '0;
            exp_ack[w] = 1'b1;
            if (s != d) begin
               exp_en = '0;
               exp_en[s] = 1'b1;
               exp_en[d] = 1'b1;
               exp_rw = 8'hFF;
               exp_rw[d] = 1'b0;
               total++;
               if (bif.REG_ENABLE !== exp_en || bif.REG_RW !== exp_rw || bif.REQ_ACK !== 4'b0000) begin
                  bad++;
                  $display("FAIL rand_xfer[%0d]: en=%b rw=%b ack=%b, want %b/%b/0000",
                           r, bif.REG_ENABLE, bif.REG_RW, bif.REQ_ACK, exp_en, exp_rw);
               end
               step();
            end
            total++;
            if (bif.REQ_ACK !== exp_ack || bif.XFER_ERR !== (s == d) || bif.REG_ENABLE !== 8'h00) begin
               bad++;
               $display("FAIL rand_ack[%0d]: ack=%b err=%b en=%h, want %b/%b/00",
                        r, bif.REQ_ACK, bif.XFER_ERR, bif.REG_ENABLE, exp_ack, (s == d));
            end
            step();
            rand_req(w);
         end
      end
      bif.REQ_VALID = '0;
      step();
      step();
      step();
   endtask

   initial begin
      for (int j = 0; j < 8; j++) bank[j] = 16'(j * 16'h1111);
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_illegal();
      test_reset_mid();
      test_out_of_range();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
Arbitrates register-to-register transfers on the shared DATA bus of the Bat Amateur datapath. It connects to a bank of bidirectional bus registers.
- Up to NUM_REQ requesters (fetch unit, microsequencer, debug port, ...) each post a source/destination register index.
- The controller picks one requester round-robin.
- It drives per-register ENABLE/RW for exactly one bus cycle, then acknowledges the winner.
- Guarantees a single bus driver per cycle and no bus contention.

Parameters:
NUM_REGS, 8, number of bus registers controlled
IDX_W, 3, register index width (2^IDX_W >= NUM_REGS)
NUM_REQ, 4, number of requesters

Ports:
CLOCK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-low reset
REQ_VALID  in  NUM_REQ  requester i has a pending transfer; held until its ACK
REQ_SRC  in  NUM_REQ*IDX_W  source index of requester i, slice [i*IDX_W +: IDX_W]
REQ_DST  in  NUM_REQ*IDX_W  destination index of requester i, same packing
REQ_ACK  out  NUM_REQ  one-cycle pulse: transfer of requester i finished or rejected
XFER_ERR  out  1  one-cycle pulse with ACK when the request was rejected
REG_ENABLE  out  NUM_REGS  bus-access enable to register j
REG_RW  out  NUM_REGS  RW to register j (1 = drive bus, 0 = load from bus)
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Register semantics:
  - A register with ENABLE=1, RW=1 drives DATA.
  - A register with ENABLE=1, RW=0 loads DATA at the next rising edge.
- FSM states: IDLE, XFER, ACK. All outputs are registered and decoded from the state plus latched fields.
- IDLE:
  - If any REQ_VALID is set, the round-robin arbiter picks the first valid requester at or after PTR+1 (mod NUM_REQ).
  - The winner id, src and dst are latched.
  - Legal request: src != dst, src < NUM_REGS, dst < NUM_REGS. Next state XFER.
  - Illegal request: next state ACK with err flag set. No enables are asserted.
  - PTR is updated to the winner id in either case.
- XFER (exactly 1 cycle):
  - REG_ENABLE has exactly bits src and dst set.
  - REG_RW[dst]=0; all other REG_RW bits are 1.
  - Destination captures DATA at the edge that leaves XFER. Next state ACK.
- ACK (1 cycle):
  - REG_ENABLE all 0.
  - REG_ACK[id]=1 and XFER_ERR=err.
  - Next state is IDLE.
- Requester contract: drop REQ_VALID, or present a new request, in the cycle after ACK is seen. The controller does not re-sample REQ_VALID until IDLE.
- Timing:
  - Request sampled in IDLE at edge k gives XFER during cycle k+1 and ACK during cycle k+2.
  - Maximum throughput is one transfer per 3 cycles.
- Default outputs (IDLE and ACK): REG_ENABLE=0, REG_RW all 1, so no register loads.
- Reset (RESET=0 at an edge), from any state:
  - state=IDLE, PTR=NUM_REQ-1 so requester 0 wins first.
  - REG_ENABLE=0, REG_RW all 1, REG_ACK=0, XFER_ERR=0, BUSY=0.
- Reset during XFER: enables drop at the reset edge. No ACK is issued for the aborted transfer.
- Changes to REQ_SRC/REQ_DST after latching have no effect on the transfer in flight.
- REQ_VALID deasserted without an ACK: the request is simply dropped if not yet latched.

Decomposition:
- Shared package/include:
  - state encodings ST_IDLE=2'd0, ST_XFER=2'd1, ST_ACK=2'd2.
  - RW_DRIVE=1'b1, RW_LOAD=1'b0 constants, reused by other bus-register controllers.
- One sub-module: rr_arbiter (NUM_REQ). Inputs: request vector and PTR. Outputs: one-hot grant, winner index and any flag. Purely combinational.
- FSM, latching and decode live in bus_xfer_ctrl.

Test Plan:
- Single transfer: req0 src=2 dst=5 valid at cycle 0. Expect:
  - cycle 1: REG_ENABLE=8'b0010_0100, REG_RW=8'b1101_1111.
  - cycle 2: REQ_ACK=4'b0001, XFER_ERR=0.
  - A bench register model at index 5 loads the value driven by register 2.
- Contention: req1 (3->4) and req3 (6->0) valid simultaneously after reset. Expect:
  - req1 served first, ACK 4'b0010.
  - req3 XFER then ACK 4'b1000 three cycles later.
  - REG_ENABLE never has more than one RW=1 bit set.
- Fairness: all four requesters held valid continuously (re-asserting after each ACK). Grant order is 0,1,2,3,0,...; no requester is skipped over 12 transfers.
- Illegal request: req2 src=4 dst=4. Expect no REG_ENABLE activity, then REQ_ACK=4'b0100 with XFER_ERR=1 one cycle after sampling.
- Reset mid-operation: RESET=0 during XFER. Expect:
  - next cycle REG_ENABLE=0, BUSY=0, no ACK.
  - after release, requester 0 is favoured first.
- Out-of-range index (NUM_REGS=6): req0 src=7 dst=1. Expect XFER_ERR=1 with ACK and no enables asserted.
